lfsr_gen: RTL

Parametrised pseudo-random sequence generator. It extends the team's fixed 8-bit LFSR with:
- configurable width and tap masks;
- run-time Fibonacci/Galois mode select;
- a step enable;
- automatic recovery from the all-zero lock-up state;
- on-line period measurement against the last loaded reference state.

It sits in the Lab4 datapath as the stimulus and scrambling source feeding downstream comparators and displays.

---
 rtl/lfsr_gen.sv | 95 +++++++++
 1 files changed

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, lock-up recovery and
// on-line period measurement against the last loaded reference state.
module lfsr_gen #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(8'hB4),
    parameter logic [WIDTH-1:0] GTAPS      = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1),
    parameter logic [WIDTH-1:0] LOCK_SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             en,
    input  logic             seed_val,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] d,
    output logic             lockup,
    output logic             wrap,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] period
);

    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] next_fib;
    logic [WIDTH-1:0] next_gal;
    logic [WIDTH-1:0] next_s;

    always_comb begin
        next_fib = {d_q[WIDTH-2:0], ^(d_q & TAPS)};
        next_gal = {d_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{d_q[WIDTH-1]}} & GTAPS);
        next_s   = mode ? next_gal : next_fib;
    end

    always_comb begin
        d_d      = d_q;
        ref_d    = ref_q;
        count_d  = count_q;
        period_d = period_q;
        lockup_d = 1'b0;
        wrap_d   = 1'b0;
        if (seed_val) begin
            d_d     = seed;
            ref_d   = seed;
            count_d = '0;
        end else if (en) begin
            if (d_q == '0) begin
                // Zero is a fixed point of both next-state functions.
                d_d      = LOCK_SEED;
                ref_d    = LOCK_SEED;
                count_d  = '0;
                lockup_d = 1'b1;
            end else begin
                d_d = next_s;
                if (next_s == ref_q) begin
                    wrap_d   = 1'b1;
                    period_d = count_q + WIDTH'(1);
                    count_d  = '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q      <= RESET_SEED;
            ref_q    <= RESET_SEED;
            count_q  <= '0;
            period_q <= '0;
            lockup_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            d_q      <= d_d;
            ref_q    <= ref_d;
            count_q  <= count_d;
            period_q <= period_d;
            lockup_q <= lockup_d;
            wrap_q   <= wrap_d;
        end
    end

    assign d      = d_q;
    assign count  = count_q;
    assign period = period_q;
    assign lockup = lockup_q;
    assign wrap   = wrap_q;

endmodule
